// File: rtl/pcs_pkg.sv
// Shared PCS transmit constants: per-lane alignment-marker codes, sync headers, BIP width.
package pcs_pkg;

   localparam int unsigned BIP_W    = 8;
   localparam int unsigned AM_LANES = 20;
   localparam logic [1:0]  SH_DATA  = 2'b01;
   localparam logic [1:0]  SH_CTRL  = 2'b10;

   // Marker code packed as {M0, M1, M2}; M0 is the first byte on the wire.
   function automatic logic [23:0] am_code(input int unsigned lane);
      logic [23:0] code;
      case (lane)
         0:       code = 24'hC16821;
         1:       code = 24'h9D718E;
         2:       code = 24'h594BE8;
         3:       code = 24'h4D957B;
         4:       code = 24'hF50709;
         5:       code = 24'hDD14C2;
         6:       code = 24'h9A4A26;
         7:       code = 24'h7B4566;
         8:       code = 24'hA02476;
         9:       code = 24'h68C9FB;
         10:      code = 24'hFD6C99;
         11:      code = 24'hB99155;
         12:      code = 24'h5CB9B2;
         13:      code = 24'h1AF8BD;
         14:      code = 24'h83C7CA;
         15:      code = 24'h3536CD;
         16:      code = 24'hC4314C;
         17:      code = 24'hADD6B7;
         18:      code = 24'h5F662A;
         19:      code = 24'hC0F0E5;
         default: code = 24'h000000;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/pcs_tx_gb_lane.sv
// One lane of the 66b->64b transmit gearbox; shared seq selects the residual length.
module pcs_tx_gb_lane #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned HEAD_W = 2,
   parameter int unsigned SEQ_W  = 6
) (
   input  logic                     clk,
   input  logic                     nreset,
   input  logic [SEQ_W-1:0]         seq,
   input  logic                     full,
   input  logic [DATA_W+HEAD_W-1:0] blk,
   output logic [DATA_W-1:0]        word
);

   localparam int unsigned BLK_W  = DATA_W + HEAD_W;
   localparam int unsigned WIDE_W = 2 * DATA_W;

   logic [DATA_W-1:0] res_q, res_d, word_q, word_d;
   logic [WIDE_W-1:0] wide;
   int unsigned       res_len;

   // New block is appended above the residual; the low DATA_W bits leave this cycle.
   always_comb begin
      res_len = 32'(seq) * HEAD_W;
      wide    = ({{(WIDE_W-BLK_W){1'b0}}, blk} << res_len) | {{(WIDE_W-DATA_W){1'b0}}, res_q};
      if (full) begin
         word_d = res_q;
         res_d  = '0;
      end else begin
         word_d = wide[DATA_W-1:0];
         res_d  = wide[WIDE_W-1:DATA_W];
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         res_q  <= '0;
         word_q <= '0;
      end else begin
         res_q  <= res_d;
         word_q <= word_d;
      end
   end

   assign word = word_q;

endmodule

// File: rtl/pcs_tx_mld.sv
// PCS transmit multi-lane distribution: slot scheduling, alignment-marker insertion, gearboxes.
// Define PCS_TX_BIP_EN to build the per-lane BIP accumulators; otherwise markers carry BIP3=00.
module pcs_tx_mld #(
   parameter int unsigned LANE_N      = 4,
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned HEAD_W      = 2,
   parameter int unsigned AM_INTERVAL = 16383
) (
   input  logic                       clk,
   input  logic                       nreset,
   input  logic                       valid_i,
   input  logic [LANE_N*HEAD_W-1:0]   head_i,
   input  logic [LANE_N*DATA_W-1:0]   data_i,
   output logic                       ready_o,
   output logic                       marker_v_o,
   output logic                       underflow_o,
   output logic [LANE_N*DATA_W-1:0]   serdes_data_o
);
   import pcs_pkg::*;

   localparam int unsigned SEQ_W   = 6;
   localparam int unsigned SEQ_MAX = DATA_W / HEAD_W;
   localparam int unsigned AM_W    = $clog2(AM_INTERVAL + 1);

   logic [SEQ_W-1:0] seq_q;
   logic [AM_W-1:0]  am_q;
   logic             underflow_q;
   logic             full;
   logic             marker;

   assign full        = (seq_q == SEQ_W'(SEQ_MAX));
   assign marker      = !full && (am_q == '0);
   assign ready_o     = !full && (am_q != '0);
   assign marker_v_o  = marker;
   assign underflow_o = underflow_q;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         seq_q       <= '0;
         am_q        <= '0;
         underflow_q <= 1'b0;
      end else begin
         seq_q <= full ? '0 : seq_q + 1'b1;
         // Full cycles carry no slot, so a marker due there slides to the next open slot.
         if (!full) am_q <= (am_q == AM_W'(AM_INTERVAL)) ? '0 : am_q + 1'b1;
         if (ready_o && !valid_i) underflow_q <= 1'b1;
      end
   end

`ifdef PCS_TX_BIP_EN
   function automatic logic [BIP_W-1:0] blk_parity(input logic [DATA_W-1:0] d);
      logic [BIP_W-1:0] p;
      p = '0;
      for (int i = 0; i < int'(DATA_W); i++) p[i % BIP_W] = p[i % BIP_W] ^ d[i];
      return p;
   endfunction
`endif

   for (genvar l = 0; l < int'(LANE_N); l++) begin : g_lane
      logic [23:0]              code;
      logic [BIP_W-1:0]         bip3;
      logic [DATA_W-1:0]        am_payload;
      logic [DATA_W-1:0]        data_pl;
      logic [HEAD_W-1:0]        data_hd;
      logic [DATA_W+HEAD_W-1:0] blk;

      assign code    = am_code(l);
      // Underflowed data slots still feed the gearbox, as an all-zero block.
      assign data_pl = valid_i ? data_i[l*DATA_W +: DATA_W] : '0;
      assign data_hd = valid_i ? head_i[l*HEAD_W +: HEAD_W] : '0;

`ifdef PCS_TX_BIP_EN
      logic [BIP_W-1:0] bip_q;
      assign bip3 = bip_q;

      always_ff @(posedge clk or negedge nreset) begin
         if (!nreset) begin
            bip_q <= '0;
         end else if (marker) begin
            bip_q <= blk_parity(am_payload);
         end else if (ready_o) begin
            bip_q <= bip_q ^ blk_parity(data_pl);
         end
      end
`else
      assign bip3 = '0;
`endif

      assign am_payload = DATA_W'({~bip3, ~code[7:0], ~code[15:8], ~code[23:16],
                                   bip3, code[7:0], code[15:8], code[23:16]});
      assign blk = marker ? {am_payload, HEAD_W'(SH_CTRL)} : {data_pl, data_hd};

      pcs_tx_gb_lane #(
         .DATA_W (DATA_W),
         .HEAD_W (HEAD_W),
         .SEQ_W  (SEQ_W)
      ) u_gb (
         .clk    (clk),
         .nreset (nreset),
         .seq    (seq_q),
         .full   (full),
         .blk    (blk),
         .word   (serdes_data_o[l*DATA_W +: DATA_W])
      );
   end

endmodule

// File: doc/pcs_tx_mld.md
PCS_TX_MLD -- requirements
Module: pcs_tx_mld

Interface
REQ-001 Parameter LANE_N, default 4, number of PCS lanes (1..20) sharing one clock.
REQ-002 Parameter DATA_W, default 64, block payload width and per-lane SerDes word width.
REQ-003 Parameter HEAD_W, default 2, sync header width.
REQ-004 Parameter AM_INTERVAL, default 16383, data slots between alignment markers (min 2).
REQ-005 clk  input  1  PCS clock; one clock, all logic on its rising edge.
REQ-006 nreset  input  1  reset, asynchronous and active-low.
REQ-007 valid_i  input  1  scrambled blocks present on head_i/data_i for all lanes.
REQ-008 head_i  input  LANE_N*HEAD_W  per-lane sync header, lane l at [l*HEAD_W +: HEAD_W].
REQ-009 data_i  input  LANE_N*DATA_W  per-lane scrambled payload, lane l at [l*DATA_W +: DATA_W].
REQ-010 ready_o  output  1  block slot open this cycle; transfer = valid_i & ready_o.
REQ-011 marker_v_o  output  1  alignment marker enters gearboxes this cycle.
REQ-012 underflow_o  output  1  sticky flag: ready_o high with valid_i low occurred.
REQ-013 serdes_data_o  output  LANE_N*DATA_W  per-lane gearboxed SerDes word, registered.

Function
REQ-014 Shared 6-bit seq counter 0..32, +1 per cycle, wraps 32->0; slot open when seq!=32 (full cycle otherwise).
REQ-015 am_cnt counts open slots 0..AM_INTERVAL, wraps to 0; full cycles do not advance it.
REQ-016 Open slot with am_cnt==0 is a marker slot; other open slots are data slots.
REQ-017 ready_o = data slot (combinational from registered state); low on full and marker cycles.
REQ-018 marker_v_o = marker slot; marker and full never coincide, full cycle defers marker to next open slot.
REQ-019 Data slot: each lane gearbox consumes its {data_i, head_i} 66b block, header in LSBs.
REQ-020 Data slot with valid_i low: lanes consume all-zero block, underflow_o set and held until reset.
REQ-021 Marker block lane l: header 2'b10; payload bytes 0..7 = M0,M1,M2,BIP3,~M0,~M1,~M2,BIP7, byte 0 at bits [7:0], M0..M2 from lane table entry l.
REQ-022 BIP7 = ~BIP3 for every marker.
REQ-023 BIP3 bit i = XOR of payload bits j (j%8==i) of all blocks sent on that lane since and including previous marker; headers excluded.
REQ-024 Per-lane BIP accumulator cleared on reset; at marker slot loaded with marker payload parity, else XORed with consumed block payload parity.
REQ-025 Gearbox at open slot seq=s: output = {low 64-2s bits of new block, 2s residual bits}, residual in LSBs; top 2s+2 bits kept as residual.
REQ-026 Gearbox at seq=32: output = 64 residual bits, residual emptied.
REQ-027 serdes_data_o registered: block consumed in cycle N contributes first bits to serdes_data_o in cycle N+1.
REQ-028 All lanes share seq and am_cnt; lane outputs always slot-aligned.

Reset
REQ-029 While nreset low: seq=0, am_cnt=0, residual=0, BIP=0, underflow_o=0, serdes_data_o=0.
REQ-030 After release first open slot is a marker (ready_o=0, marker_v_o=1), BIP3=8'h00.
REQ-031 Reset mid-stream discards residual bits and partially accumulated BIP immediately.

Configuration
REQ-032 Macro PCS_TX_BIP_EN defined: BIP accumulators built, REQ-023/024 apply.
REQ-033 PCS_TX_BIP_EN undefined: no accumulators; BIP3=8'h00, BIP7=8'hFF in every marker.

Structure
REQ-034 Shared package pcs_pkg holds marker lane table (20 x 24b M0..M2), sync header constants (2'b01 data, 2'b10 ctrl), BIP width.
REQ-035 One sub-module pcs_tx_gb_lane (66->64 gearbox + residual), instantiated LANE_N times; seq, am_cnt, ready in top.

Verification
REQ-036 Reset release, LANE_N=4, AM_INTERVAL=4 -> cycle 1 marker_v_o=1, ready_o=0, lane0 bytes 0..2 = table entry 0, BIP3=00.
REQ-037 Continuous valid_i, AM_INTERVAL=4 -> marker every 5th open slot; ready_o low on seq=32 only otherwise; 33 cycles carry 32 slots.
REQ-038 Lane0 data 64'h1 x4 after marker -> next BIP3 = parity of marker + blocks per REQ-023, BIP7 = ~BIP3 (BIP_EN on); BIP3=00/BIP7=FF (off).
REQ-039 Marker due at seq=32 -> marker_v_o asserted at seq=0 of next cycle, am_cnt unchanged across full cycle.
REQ-040 valid_i=0 for one data slot -> underflow_o=1 next cycle, stays 1 until nreset.
REQ-041 nreset pulsed mid-block -> outputs zero, then marker as first open slot, residual bits absent from serdes_data_o.
